// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Free-running raster timing generator. A horizontal counter (hc) steps once
// per pixel clock and a vertical counter (vc) steps once per line. Every
// output is a register that describes the pixel (hc,vc) currently on the
// wire, so sprite ROM/palette stages can use DrawX/DrawY directly as a pixel
// address and blank as an output enable.
//
// Ports:
//   vga_clk      in   pixel clock; all state changes on the rising edge
//   reset_n      in   asynchronous, active-low reset
//   DrawX        out  [9:0]  current horizontal count, 0..H_TOTAL-1
//   DrawY        out  [9:0]  current vertical count,   0..V_TOTAL-1
//   blank        out  1 = visible pixel (display enable), 0 = blanking
//   hs           out  horizontal sync, active-low
//   vs           out  vertical sync, active-low
//   frame_start  out  one-cycle pulse at pixel (0,0)
//   line_end     out  one-cycle pulse on the last clock of every line
//   frame_count  out  [FC_W-1:0] frames started since reset, wraps
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FC_W      = 16
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic            blank,
  output logic            hs,
  output logic            vs,
  output logic            frame_start,
  output logic            line_end,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // All decode thresholds held at counter width so comparisons stay 10-bit.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]      hc_q, hc_d;
  logic [9:0]      vc_q, vc_d;
  logic            blank_q, blank_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            frame_start_q, frame_start_d;
  logic            line_end_q, line_end_d;
  logic [FC_W-1:0] frame_count_q, frame_count_d;

  // Next-state counters, then decode of the *next* pixel so the registered
  // outputs line up with the registered counters in the same cycle and no
  // combinational path reaches the pins.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end else begin
      hc_d = hc_q + 10'd1;
    end

    blank_d       = (hc_d < H_VIS_END) && (vc_d < V_VIS_END);
    hs_d          = !((hc_d >= H_SYNC_BEG) && (hc_d < H_SYNC_END));
    vs_d          = !((vc_d >= V_SYNC_BEG) && (vc_d < V_SYNC_END));
    frame_start_d = (hc_d == '0) && (vc_d == '0);
    line_end_d    = (hc_d == H_LAST);

    // The counter bumps on the edge that enters (0,0), together with the pulse.
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + FC_W'(1);
    end
  end

  // Reset parks the raster on the last pixel of the frame, so the first edge
  // after release lands on (0,0) and starts frame 1. The reset output values
  // are exactly the decode of that parked pixel.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= H_LAST;
      vc_q          <= V_LAST;
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b1;
      frame_count_q <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign frame_start = frame_start_q;
  assign line_end    = line_end_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share one clock: the default 640x480 raster (a), a small
// raster with a 2-bit frame counter (b), and a 4x3 visible raster (c).
// Expected outputs come from a reference model that maps "clock edges since
// reset release" straight to a pixel position and frame number with modular
// arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;

  logic [9:0]  x_a, y_a, x_b, y_b, x_c, y_c;
  logic        bl_a, hs_a, vs_a, fs_a, le_a;
  logic        bl_b, hs_b, vs_b, fs_b, le_b;
  logic        bl_c, hs_c, vs_c, fs_c, le_c;
  logic [15:0] fc_a;
  logic [1:0]  fc_b;
  logic [3:0]  fc_c;

  vga_timing_gen u_a (
    .vga_clk(clk), .reset_n(rst_a), .DrawX(x_a), .DrawY(y_a), .blank(bl_a),
    .hs(hs_a), .vs(vs_a), .frame_start(fs_a), .line_end(le_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .FC_W(2)
  ) u_b (
    .vga_clk(clk), .reset_n(rst_b), .DrawX(x_b), .DrawY(y_b), .blank(bl_b),
    .hs(hs_b), .vs(vs_b), .frame_start(fs_b), .line_end(le_b), .frame_count(fc_b)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .FC_W(4)
  ) u_c (
    .vga_clk(clk), .reset_n(rst_c), .DrawX(x_c), .DrawY(y_c), .blank(bl_c),
    .hs(hs_c), .vs(vs_c), .frame_start(fs_c), .line_end(le_c), .frame_count(fc_c)
  );

  // Observed outputs packed as {x, y, blank, hs, vs, frame_start, line_end, fc}
  logic [40:0] act_a, act_b, act_c;
  assign act_a = {x_a, y_a, bl_a, hs_a, vs_a, fs_a, le_a, fc_a};
  assign act_b = {x_b, y_b, bl_b, hs_b, vs_b, fs_b, le_b, 14'd0, fc_b};
  assign act_c = {x_c, y_c, bl_c, hs_c, vs_c, fs_c, le_c, 12'd0, fc_c};

  int total = 0;
  int bad   = 0;
  int k_a = 0, k_b = 0, k_c = 0;   // rising edges since reset release

  // Reference model: k = 0 is the reset state; edge k >= 1 shows raster
  // position k-1 (mod one frame) of frame number ceil(k / frame length).
  function automatic logic [40:0] model(input int hv, input int hf, input int hsy,
                                        input int hb, input int vv, input int vf,
                                        input int vsy, input int vb, input int fcw,
                                        input int k);
    int ht, vt, p, x, y, frames;
    logic [9:0]  xo, yo;
    logic [15:0] fc;
    logic        b, h, v, f, l;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    if (k == 0) begin
      xo = 10'(ht - 1); yo = 10'(vt - 1);
      b = 1'b0; h = 1'b1; v = 1'b1; f = 1'b0; l = 1'b1; fc = 16'd0;
    end else begin
      p      = (k - 1) % (ht * vt);
      x      = p % ht;
      y      = p / ht;
      frames = (k - 1) / (ht * vt) + 1;
      xo = 10'(x); yo = 10'(y);
      b  = (x < hv) && (y < vv);
      h  = !((x >= hv + hf) && (x < hv + hf + hsy));
      v  = !((y >= vv + vf) && (y < vv + vf + vsy));
      f  = (x == 0) && (y == 0);
      l  = (x == ht - 1);
      fc = 16'(frames % (1 << fcw));
    end
    return {xo, yo, b, h, v, f, l, fc};
  endfunction

  function automatic logic [40:0] exp_a(input int k);
    return model(640, 16, 96, 48, 480, 10, 2, 33, 16, k);
  endfunction
  function automatic logic [40:0] exp_b(input int k);
    return model(8, 2, 3, 2, 6, 1, 2, 1, 2, k);
  endfunction
  function automatic logic [40:0] exp_c(input int k);
    return model(4, 1, 1, 1, 3, 1, 1, 1, 4, k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one instance in reset for a random number of clocks, release it on
  // a falling edge and zero its edge count.
  task automatic restart(input int which);
    int n;
    n = $urandom_range(2, 6);
    @(negedge clk);
    if (which == 1) rst_b = 1'b0; else rst_c = 1'b0;
    repeat (n) tick();
    @(negedge clk);
    if (which == 1) begin rst_b = 1'b1; k_b = 0; end
    else begin rst_c = 1'b1; k_c = 0; end
  endtask

  task automatic test_reset();
    repeat (5) tick();
    total++; if (act_a !== exp_a(0)) begin bad++; $display("FAIL reset_a got=%h exp=%h", act_a, exp_a(0)); end
    total++; if (act_b !== exp_b(0)) begin bad++; $display("FAIL reset_b got=%h exp=%h", act_b, exp_b(0)); end
    total++; if (act_c !== exp_c(0)) begin bad++; $display("FAIL reset_c got=%h exp=%h", act_c, exp_c(0)); end
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick(); k_a = 1; k_b = 1; k_c = 1;
    total++; if (act_a !== exp_a(1)) begin bad++; $display("FAIL first_edge_a got=%h exp=%h", act_a, exp_a(1)); end
    total++; if (act_b !== exp_b(1)) begin bad++; $display("FAIL first_edge_b got=%h exp=%h", act_b, exp_b(1)); end
    total++; if (act_c !== exp_c(1)) begin bad++; $display("FAIL first_edge_c got=%h exp=%h", act_c, exp_c(1)); end
    $display("test_reset: reset state and first edge checked");
  endtask

  task automatic test_line_timing();
    int hs_fall = -1, hs_rise = -1, bl_fall = -1, wraps = 0, le_bad = 0;
    logic phs, pbl;
    logic [9:0] px, py;
    phs = hs_a; pbl = bl_a; px = x_a; py = y_a;
    for (int i = 0; i < 1700; i++) begin
      tick(); k_a++;
      total++;
      if (act_a !== exp_a(k_a)) begin
        bad++; $display("FAIL line_cycle k=%0d got=%h exp=%h", k_a, act_a, exp_a(k_a));
      end
      if (phs && !hs_a && hs_fall < 0) hs_fall = int'(x_a);
      if (!phs && hs_a && hs_rise < 0) hs_rise = int'(x_a);
      if (pbl && !bl_a && bl_fall < 0) bl_fall = int'(x_a);
      if (px == 10'd799 && x_a == 10'd0 && y_a == py + 10'd1) wraps++;
      if (le_a && x_a != 10'd799) le_bad++;
      phs = hs_a; pbl = bl_a; px = x_a; py = y_a;
    end
    total++; if (hs_fall != 656) begin bad++; $display("FAIL hs_fall_x got=%0d exp=656", hs_fall); end
    total++; if (hs_rise != 752) begin bad++; $display("FAIL hs_rise_x got=%0d exp=752", hs_rise); end
    total++; if (bl_fall != 640) begin bad++; $display("FAIL blank_fall_x got=%0d exp=640", bl_fall); end
    total++; if (wraps != 2) begin bad++; $display("FAIL line_wraps got=%0d exp=2", wraps); end
    total++; if (le_bad != 0) begin bad++; $display("FAIL line_end_stray got=%0d exp=0", le_bad); end
    $display("test_line_timing: hs %0d..%0d blank falls at %0d", hs_fall, hs_rise, bl_fall);
  endtask

  task automatic test_mid_reset_a();
    int n, hold;
    n    = $urandom_range(10, 1500);
    hold = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) begin
      tick(); k_a++;
      total++; if (act_a !== exp_a(k_a)) begin bad++; $display("FAIL pre_reset_a k=%0d got=%h exp=%h", k_a, act_a, exp_a(k_a)); end
    end
    #2 rst_a = 1'b0;
    #1;
    total++; if (act_a !== exp_a(0)) begin bad++; $display("FAIL async_reset_a got=%h exp=%h", act_a, exp_a(0)); end
    repeat (hold) tick();
    @(negedge clk); rst_a = 1'b1; k_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); k_a++;
      total++; if (act_a !== exp_a(k_a)) begin bad++; $display("FAIL post_reset_a k=%0d got=%h exp=%h", k_a, act_a, exp_a(k_a)); end
    end
    $display("test_mid_reset_a: reset after %0d edges, held %0d clocks", n, hold);
  endtask

  task automatic test_frame_timing();
    int fs_k[$], fs_fc[$];
    int viol = 0, vs_low = 0, bl_cnt = 0;
    restart(1);
    for (int i = 0; i < 301; i++) begin
      tick(); k_b++;
      total++; if (act_b !== exp_b(k_b)) begin bad++; $display("FAIL frame_cycle k=%0d got=%h exp=%h", k_b, act_b, exp_b(k_b)); end
      if (fs_b) begin fs_k.push_back(k_b); fs_fc.push_back(int'(fc_b)); end
      if (!vs_b && !(y_b == 10'd7 || y_b == 10'd8)) viol++;
      if (y_b >= 10'd6 && bl_b) viol++;
      if (!vs_b) vs_low++;
      if (bl_b) bl_cnt++;
    end
    total++; if (fs_k.size() != 3) begin bad++; $display("FAIL frame_pulses got=%0d exp=3", fs_k.size()); end
    else begin
      total++; if (fs_k[1] - fs_k[0] != 150 || fs_k[2] - fs_k[1] != 150) begin
        bad++; $display("FAIL frame_period got=%0d,%0d exp=150", fs_k[1] - fs_k[0], fs_k[2] - fs_k[1]); end
      for (int j = 0; j < 3; j++) begin
        total++; if (fs_fc[j] != j + 1) begin bad++; $display("FAIL frame_count_%0d got=%0d exp=%0d", j, fs_fc[j], j + 1); end
      end
    end
    total++; if (viol != 0) begin bad++; $display("FAIL vs_blank_window got=%0d exp=0", viol); end
    total++; if (vs_low != 60) begin bad++; $display("FAIL vs_low_clocks got=%0d exp=60", vs_low); end
    total++; if (bl_cnt != 97) begin bad++; $display("FAIL blank_clocks got=%0d exp=97", bl_cnt); end
    $display("test_frame_timing: %0d frame pulses, vs low %0d clocks", fs_k.size(), vs_low);
  endtask

  task automatic test_counter_wrap();
    int seq[$];
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    restart(1);
    for (int i = 0; i < 750; i++) begin
      tick(); k_b++;
      total++; if (act_b !== exp_b(k_b)) begin bad++; $display("FAIL wrap_cycle k=%0d got=%h exp=%h", k_b, act_b, exp_b(k_b)); end
      if (fs_b) seq.push_back(int'(fc_b));
    end
    total++; if (seq.size() != 5) begin bad++; $display("FAIL wrap_pulses got=%0d exp=5", seq.size()); end
    else begin
      for (int j = 0; j < 5; j++) begin
        total++; if (seq[j] != exp_seq[j]) begin bad++; $display("FAIL wrap_fc_%0d got=%0d exp=%0d", j, seq[j], exp_seq[j]); end
      end
    end
    $display("test_counter_wrap: %0d frames observed", seq.size());
  endtask

  task automatic test_mid_frame_reset();
    int n;
    n = $urandom_range(1, 300);
    for (int i = 0; i < n; i++) begin
      tick(); k_b++;
      total++; if (act_b !== exp_b(k_b)) begin bad++; $display("FAIL pre_reset_b k=%0d got=%h exp=%h", k_b, act_b, exp_b(k_b)); end
    end
    #2 rst_b = 1'b0;
    #1;
    total++; if (act_b !== exp_b(0)) begin bad++; $display("FAIL async_reset_b got=%h exp=%h", act_b, exp_b(0)); end
    repeat ($urandom_range(1, 4)) tick();
    total++; if (act_b !== exp_b(0)) begin bad++; $display("FAIL held_reset_b got=%h exp=%h", act_b, exp_b(0)); end
    @(negedge clk); rst_b = 1'b1; k_b = 0;
    for (int i = 0; i < 160; i++) begin
      tick(); k_b++;
      total++; if (act_b !== exp_b(k_b)) begin bad++; $display("FAIL post_reset_b k=%0d got=%h exp=%h", k_b, act_b, exp_b(k_b)); end
    end
    $display("test_mid_frame_reset: reset after %0d edges", n);
  endtask

  task automatic test_param_override();
    int le_k[$], fs_k[$];
    int hs_low = 0, vs_low = 0, bl_cnt = 0;
    restart(2);
    for (int i = 0; i < 85; i++) begin
      tick(); k_c++;
      total++; if (act_c !== exp_c(k_c)) begin bad++; $display("FAIL tiny_cycle k=%0d got=%h exp=%h", k_c, act_c, exp_c(k_c)); end
      if (le_c) le_k.push_back(k_c);
      if (fs_c) fs_k.push_back(k_c);
      if (!hs_c) hs_low++;
      if (!vs_c) vs_low++;
      if (bl_c) bl_cnt++;
    end
    total++; if (le_k.size() < 2 || le_k[1] - le_k[0] != 7) begin
      bad++; $display("FAIL h_total got=%0d exp=7", (le_k.size() < 2) ? -1 : le_k[1] - le_k[0]); end
    total++; if (fs_k.size() < 2 || fs_k[1] - fs_k[0] != 42) begin
      bad++; $display("FAIL frame_len got=%0d exp=42", (fs_k.size() < 2) ? -1 : fs_k[1] - fs_k[0]); end
    total++; if (hs_low != 12) begin bad++; $display("FAIL tiny_hs_low got=%0d exp=12", hs_low); end
    total++; if (vs_low != 14) begin bad++; $display("FAIL tiny_vs_low got=%0d exp=14", vs_low); end
    total++; if (bl_cnt != 25) begin bad++; $display("FAIL tiny_blank got=%0d exp=25", bl_cnt); end
    $display("test_param_override: hs low %0d, vs low %0d, visible %0d", hs_low, vs_low, bl_cnt);
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_mid_reset_a();
    test_frame_timing();
    test_counter_wrap();
    test_mid_frame_reset();
    test_param_override();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
